mips_multicycle_ctrl: RTL
=========================

Name: mips_multicycle_ctrl

Overview:
Moore-style control FSM that sequences the multicycle MIPS datapath: instruction fetch, field breakdown, execute, memory and writeback. It consumes the opcode and function fields produced by the instruction field decoder. It drives every datapath enable and mux select, waits on a memory-ready handshake, and counts retired instructions. It sits beside the register file, ALU and memory interface in the processor top level.

Parameters:
STATE_W, 4, width of the state register (exported on the debug port)
CNT_W, 32, width of the retired-instruction counter

Ports:
clk  in  1  single processor clock; all flops on the rising edge
reset  in  1  asynchronous, active-high; forces the IDLE state and clears the counter
op  in  6  opcode field inst[31:26] from the field decoder
func  in  6  function field inst[5:0] from the field decoder
zero  in  1  ALU zero flag; sampled in BRANCH
mem_ready  in  1  memory completes the current access this cycle
pc_write  out  1  unconditional PC load
pc_write_cond  out  1  PC load if branch is taken
branch_ne  out  1  1 = bne sense (taken when zero=0)
pc_src  out  2  0 = ALU result, 1 = ALUOut, 2 = jump target {pc[31:28], jumper, 2'b00}, 3 = register rs
ir_write  out  1  instruction register load
iord  out  1  memory address select: 0 = PC, 1 = ALUOut
mem_read  out  1  memory read request
mem_write  out  1  memory write request
reg_write  out  1  register file write enable
reg_dst  out  2  0 = rt, 1 = rd, 2 = $31
mem_to_reg  out  2  0 = ALUOut, 1 = MDR, 2 = PC (link)
alu_src_a  out  1  0 = PC, 1 = A register
alu_src_b  out  2  0 = B, 1 = constant 4, 2 = sign-extended imm, 3 = sign-extended imm << 2
alu_op  out  3  0 = add, 1 = sub, 2 = R-type (ALU control decodes func), 3 = and, 4 = or, 5 = slt
illegal  out  1  sticky flag: an undefined op/func was decoded
state  out  STATE_W  current state, for debug
retired  out  CNT_W  count of completed instructions

Behaviour:
- Reset (asynchronous): state = IDLE, retired = 0, illegal = 0. In IDLE all outputs are 0. IDLE always goes to FETCH on the next clock.
- Outputs are decoded combinationally from state only, except where gated by mem_ready as noted below. Outputs not listed for a state are 0.
- FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=1, alu_op=add.
  - ir_write and pc_write assert only when mem_ready=1, in the same cycle, with pc_src=0.
  - Stay in FETCH while mem_ready=0. Go to DECODE when mem_ready=1.
- DECODE: alu_src_a=0, alu_src_b=3, alu_op=add (computes the branch target). Next state by opcode:
  - op 000000, func 001000 (jr) -> JR
  - op 000000, other func -> EXEC_R
  - op 100011 (lw) or 101011 (sw) -> ADDR
  - op 000100 (beq) or 000101 (bne) -> BRANCH
  - op 001000 (addi), 001100 (andi), 001101 (ori), 001010 (slti) -> EXEC_I
  - op 000010 (j) -> JUMP
  - op 000011 (jal) -> JAL
  - any other op -> TRAP
- EXEC_R: alu_src_a=1, alu_src_b=0, alu_op=2 -> WB_R.
- WB_R: reg_write=1, reg_dst=1, mem_to_reg=0 -> FETCH; retire.
- EXEC_I: alu_src_a=1, alu_src_b=2, alu_op = add/and/or/slt selected by the latched op -> WB_I.
- WB_I: reg_write=1, reg_dst=0, mem_to_reg=0 -> FETCH; retire.
- ADDR: alu_src_a=1, alu_src_b=2, alu_op=add -> MEM_RD for lw, MEM_WR for sw.
- MEM_RD: mem_read=1, iord=1. Hold while mem_ready=0; go to WB_MEM when mem_ready=1.
- WB_MEM: reg_write=1, reg_dst=0, mem_to_reg=1 -> FETCH; retire.
- MEM_WR: mem_write=1, iord=1. Hold while mem_ready=0; go to FETCH when mem_ready=1; retire on that exit.
- BRANCH: alu_src_a=1, alu_src_b=0, alu_op=sub, pc_write_cond=1, pc_src=1, branch_ne = (op==000101) -> FETCH; retire.
- JUMP: pc_write=1, pc_src=2 -> FETCH; retire.
- JAL: pc_write=1, pc_src=2, reg_write=1, reg_dst=2, mem_to_reg=2 -> FETCH; retire.
- JR: pc_write=1, pc_src=3 -> FETCH; retire.
- TRAP: sets illegal=1 (sticky until reset), all other outputs 0. Remains in TRAP until reset. No retire.
- op and func are captured into internal registers in DECODE. Later states use the captured copies, so the FSM does not depend on the IR staying stable.
- retired increments by 1 in the cycle the FSM leaves a final state toward FETCH, and wraps modulo 2^CNT_W.
- Simultaneous events: mem_ready=1 outside FETCH/MEM_RD/MEM_WR is ignored. Reset asserted mid-access drops mem_read/mem_write immediately, because the reset is asynchronous.
- Latency per instruction (mem_ready tied to 1): R-type and I-type 4 cycles; lw 5; sw 4; beq/bne, j, jal, jr 3.

Decomposition:
- Shared package mips_pkg: opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI, OP_J, OP_JAL), FUNC_JR, the alu_op encodings, the pc_src/reg_dst/mem_to_reg encodings, and the state encodings.
- One sub-module, mips_ctrl_outdec: purely combinational state -> control-word decoder. The top module holds the state register, the captured op/func, the illegal flag and the retired counter.

Test Plan:
- Reset, then add (op=0, func=100000) with mem_ready=1 -> states IDLE, FETCH, DECODE, EXEC_R, WB_R; reg_write=1 and reg_dst=1 in WB_R; retired=1.
- lw (op=100011) with mem_ready held 0 for 3 cycles in MEM_RD -> mem_read=1 and iord=1 for 4 cycles; WB_MEM asserts mem_to_reg=1; 5 cycles + 3 wait cycles total.
- beq with zero=1, then bne with zero=1 -> pc_write_cond=1 and pc_src=1 both times; branch_ne=0 then 1; retired increments by 2.
- jal (op=000011) -> JAL state: pc_write=1, pc_src=2, reg_write=1, reg_dst=2, mem_to_reg=2; next state FETCH.
- op=111111 -> TRAP; illegal=1 persists for 10 cycles with all enables 0; reset asserted asynchronously mid-cycle clears illegal and state to IDLE.
- FETCH with mem_ready=0 for 2 cycles, then 1 -> ir_write and pc_write each high for exactly one cycle.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg: opcode, control-field and state encodings shared by the multicycle controller
package mips_pkg;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] FUNC_JR  = 6'b001000;
  localparam logic [2:0] ALU_ADD   = 3'd0;
  localparam logic [2:0] ALU_SUB   = 3'd1;
  localparam logic [2:0] ALU_RTYPE = 3'd2;
  localparam logic [2:0] ALU_AND   = 3'd3;
  localparam logic [2:0] ALU_OR    = 3'd4;
  localparam logic [2:0] ALU_SLT   = 3'd5;
  localparam logic [1:0] PC_ALU    = 2'd0;
  localparam logic [1:0] PC_ALUOUT = 2'd1;
  localparam logic [1:0] PC_JUMP   = 2'd2;
  localparam logic [1:0] PC_RS     = 2'd3;
  localparam logic [1:0] RD_RT = 2'd0;
  localparam logic [1:0] RD_RD = 2'd1;
  localparam logic [1:0] RD_RA = 2'd2;
  localparam logic [1:0] M2R_ALU = 2'd0;
  localparam logic [1:0] M2R_MDR = 2'd1;
  localparam logic [1:0] M2R_PC  = 2'd2;
  localparam logic [1:0] SRCB_B   = 2'd0;
  localparam logic [1:0] SRCB_4   = 2'd1;
  localparam logic [1:0] SRCB_IMM = 2'd2;
  localparam logic [1:0] SRCB_BR  = 2'd3;
  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC_R, S_WB_R, S_EXEC_I, S_WB_I, S_ADDR,
    S_MEM_RD, S_WB_MEM, S_MEM_WR, S_BRANCH, S_JUMP, S_JAL, S_JR, S_TRAP
  } state_t;
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       branch_ne;
    logic [1:0] pc_src;
    logic       ir_write;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
  } ctrl_t;
  function automatic state_t decode_op(input logic [5:0] op, input logic [5:0] func);
    if (op == OP_RTYPE) return (func == FUNC_JR) ? S_JR : S_EXEC_R;
    if (op == OP_LW || op == OP_SW) return S_ADDR;
    if (op == OP_BEQ || op == OP_BNE) return S_BRANCH;
    if (op == OP_ADDI || op == OP_ANDI || op == OP_ORI || op == OP_SLTI) return S_EXEC_I;
    if (op == OP_J) return S_JUMP;
    if (op == OP_JAL) return S_JAL;
    return S_TRAP;
  endfunction
endpackage

// File: rtl/mips_ctrl_outdec.sv
// mips_ctrl_outdec: combinational state -> control word; inputs state, captured opcode, mem_ready; output ctrl
module mips_ctrl_outdec
  import mips_pkg::*;
(
  input  state_t     state,
  input  logic [5:0] op_q,
  input  logic       mem_ready,
  output ctrl_t      ctrl
);
  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_4;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      S_DECODE: ctrl.alu_src_b = SRCB_BR;
      S_EXEC_R: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op    = ALU_RTYPE;
      end
      S_WB_R: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = RD_RD;
      end
      S_EXEC_I: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = op_q == OP_ANDI ? ALU_AND :
                         op_q == OP_ORI  ? ALU_OR  :
                         op_q == OP_SLTI ? ALU_SLT : ALU_ADD;
      end
      S_WB_I: ctrl.reg_write = 1'b1;
      S_ADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
      end
      S_MEM_RD: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
      end
      S_WB_MEM: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = M2R_MDR;
      end
      S_MEM_WR: begin
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_op        = ALU_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_src        = PC_ALUOUT;
        ctrl.branch_ne     = op_q == OP_BNE;
      end
      S_JUMP: begin
        ctrl.pc_write = 1'b1;
        ctrl.pc_src   = PC_JUMP;
      end
      S_JAL: begin
        ctrl.pc_write   = 1'b1;
        ctrl.pc_src     = PC_JUMP;
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = RD_RA;
        ctrl.mem_to_reg = M2R_PC;
      end
      S_JR: begin
        ctrl.pc_write = 1'b1;
        ctrl.pc_src   = PC_RS;
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl: multicycle MIPS control FSM; inputs op/func/zero/mem_ready, outputs datapath controls, sticky illegal, debug state and retired count
module mips_multicycle_ctrl
  import mips_pkg::*;
#(
  parameter int STATE_W = 4,
  parameter int CNT_W   = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         op,
  input  logic [5:0]         func,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               pc_write_cond,
  output logic               branch_ne,
  output logic [1:0]         pc_src,
  output logic               ir_write,
  output logic               iord,
  output logic               mem_read,
  output logic               mem_write,
  output logic               reg_write,
  output logic [1:0]         reg_dst,
  output logic [1:0]         mem_to_reg,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [2:0]         alu_op,
  output logic               illegal,
  output logic [STATE_W-1:0] state,
  output logic [CNT_W-1:0]   retired
);
  state_t     state_q, nxt;
  logic [5:0] op_q;
  logic       retire;
  ctrl_t      ctrl;
  // zero only matters to the datapath's branch-taken logic, not to sequencing
  logic       unused_zero;
  assign unused_zero = zero;
  always_comb begin
    nxt = state_q;
    case (state_q)
      S_IDLE:   nxt = S_FETCH;
      S_FETCH:  nxt = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: nxt = decode_op(op, func);
      S_EXEC_R: nxt = S_WB_R;
      S_EXEC_I: nxt = S_WB_I;
      S_ADDR:   nxt = op_q == OP_SW ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD: nxt = mem_ready ? S_WB_MEM : S_MEM_RD;
      S_MEM_WR: nxt = mem_ready ? S_FETCH : S_MEM_WR;
      S_TRAP:   nxt = S_TRAP;
      default:  nxt = S_FETCH;
    endcase
  end
  // Every path into FETCH other than IDLE start-up or a FETCH wait ends an instruction
  assign retire = nxt == S_FETCH && state_q != S_FETCH && state_q != S_IDLE;
  // func is consumed only by the DECODE branch, so only op needs a captured copy
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      illegal <= 1'b0;
      retired <= '0;
    end else begin
      state_q <= nxt;
      if (state_q == S_DECODE) op_q <= op;
      if (nxt == S_TRAP) illegal <= 1'b1;
      if (retire) retired <= retired + CNT_W'(1);
    end
  mips_ctrl_outdec u_outdec (
    .state     (state_q),
    .op_q      (op_q),
    .mem_ready (mem_ready),
    .ctrl      (ctrl)
  );
  assign state         = STATE_W'(state_q);
  assign pc_write      = ctrl.pc_write;
  assign pc_write_cond = ctrl.pc_write_cond;
  assign branch_ne     = ctrl.branch_ne;
  assign pc_src        = ctrl.pc_src;
  assign ir_write      = ctrl.ir_write;
  assign iord          = ctrl.iord;
  assign mem_read      = ctrl.mem_read;
  assign mem_write     = ctrl.mem_write;
  assign reg_write     = ctrl.reg_write;
  assign reg_dst       = ctrl.reg_dst;
  assign mem_to_reg    = ctrl.mem_to_reg;
  assign alu_src_a     = ctrl.alu_src_a;
  assign alu_src_b     = ctrl.alu_src_b;
  assign alu_op        = ctrl.alu_op;
endmodule
